conv3x3: RTL and testbench
==========================

CONV3X3 -- requirements
Module: conv3x3

Interface
REQ-001 SHALL have parameter: IMG_W, 64, input frame width in pixels (3..1023).
REQ-002 SHALL have parameter: IMG_H, 64, input frame height in lines (3..1023).
REQ-003 SHALL have parameter: SHIFT, 6, arithmetic right-shift applied to the accumulator sum (0..15).
REQ-004 SHALL have parameter: RELU, 1, 1 = clamp negative results to 0.
REQ-005 SHALL have one clock; reset is asynchronous and active-low: ports clk (input, 1, rising-edge clock) and rst_n (input, 1, async active-low reset), listed first.
REQ-006 SHALL have port: valid_in  input  1  pixel_in valid this cycle.
REQ-007 SHALL have port: pixel_in  input  8  unsigned raster-order pixel.
REQ-008 SHALL have port: frame_start  input  1  qualified by valid_in; marks pixel (0,0).
REQ-009 SHALL have port: w_we  input  1  weight write strobe.
REQ-010 SHALL have port: w_addr  input  4  weight index 0..8, row-major, 0 = top-left.
REQ-011 SHALL have port: w_data  input  8  signed weight.
REQ-012 SHALL have port: data_out  output  12  signed activation to the downstream pooling stage.
REQ-013 SHALL have port: x_out / y_out  output  10 each  output-pixel coordinates.
REQ-014 SHALL have port: valid_out  output  1  data_out/x_out/y_out valid.

Function
REQ-015 SHALL keep col/row counters that advance only on valid_in: col wraps at IMG_W-1 and increments row; row wraps at IMG_H-1 to 0.
REQ-016 SHALL treat valid_in&&frame_start as pixel (0,0) regardless of counter state; the next pixel is (1,0).
REQ-017 SHALL buffer the two previous lines in two IMG_W-deep line buffers and a 3x3 window register, shifting only on valid_in.
REQ-018 SHALL compute a valid (unpadded) convolution: a window is complete when the accepted pixel has row>=2 and col>=2; output coordinates x=col-2, y=row-2; there are (IMG_W-2)*(IMG_H-2) outputs per frame.
REQ-019 SHALL produce no output for rows 0-1 or cols 0-1; stale line-buffer contents from a previous frame or from before reset never reach valid_out.
REQ-020 SHALL zero-extend the pixel to a signed 9-bit value, form 17-bit products and a 21-bit signed sum, then apply an arithmetic shift right by SHIFT (round toward -inf).
REQ-021 SHALL apply ReLU (if RELU=1), then saturate to [-2048, 2047].
REQ-022 SHALL run a free-running 3-stage pipeline (multiply, adder tree, shift/ReLU/saturate); valid_out rises exactly 3 clk after the valid_in that completes the window; valid_in bubbles propagate as valid_out bubbles with no stall and no backpressure.
REQ-023 SHALL hold data_out, x_out and y_out at their last values while valid_out=0.
REQ-024 SHALL write w_data to weight[w_addr] on w_we when w_addr<=8; w_addr 9..15 SHALL be ignored.
REQ-025 SHALL apply a weight written in cycle N to windows entering the multiply stage in cycle N+1 or later; a simultaneous valid_in and w_we in cycle N SHALL use the old weight.

Reset
REQ-026 SHALL on rst_n low asynchronously clear valid_out, data_out, x_out, y_out, the col/row counters, all pipeline valid flags and all nine weights to 0.
REQ-027 SHALL leave line-buffer RAM contents unreset; REQ-019 guarantees they are never output.
REQ-028 SHALL, after a mid-frame reset, treat the next accepted pixel as (0,0).

Structure
REQ-029 SHALL take shared constants PIX_W=8, WGT_W=8, ACT_W=12, COORD_W=10, ACT_MAX=2047 and ACT_MIN=-2048 from the shared package cnn_pkg, which the pooling stage also uses.
REQ-030 SHALL implement each line buffer as one instance of the sub-module line_buffer (parameter DEPTH, 8-bit, one write and one read per valid_in, inferable as block RAM).

Verification
REQ-031 SHALL cover: weight[4]=64 with others 0, SHIFT=6, pixel=col ramp on a 64x64 frame -> data_out=x_out+1 at every output; 3844 outputs.
REQ-032 SHALL cover: all weights=1, SHIFT=0, constant pixel 255 -> 2295 saturates, so every data_out=2047.
REQ-033 SHALL cover: weight[0]=-8 with others 0, SHIFT=6, pixel 100 -> data_out=0 with RELU=1, and data_out=-13 with RELU=0.
REQ-034 SHALL cover: first output (x=0,y=0) 3 clk after pixel (2,2) is accepted; frame_start asserted mid-frame -> counters resync and no output until new row 2 col 2.
REQ-035 SHALL cover: random valid_in bubbles (50%) -> output value/coordinate sequence identical to the gapless run.
REQ-036 SHALL cover: rst_n pulsed mid-frame -> valid_out/data_out=0 immediately, weights read back as producing 0 output, next frame correct after reload.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and types.
// Used by the convolution and pooling stages.
package cnn_pkg;

    localparam int PIX_W   = 8;
    localparam int WGT_W   = 8;
    localparam int ACT_W   = 12;
    localparam int COORD_W = 10;
    localparam int ACT_MAX = 2047;
    localparam int ACT_MIN = -2048;

    localparam int NTAPS  = 9;
    localparam int PROD_W = PIX_W + 1 + WGT_W;
    localparam int SUM_W  = PROD_W + 4;

    typedef logic [PIX_W-1:0]          pix_t;
    typedef logic signed [WGT_W-1:0]   wgt_t;
    typedef logic signed [PROD_W-1:0]  prod_t;
    typedef logic signed [SUM_W-1:0]   sum_t;
    typedef logic signed [ACT_W-1:0]   act_t;
    typedef logic [COORD_W-1:0]        coord_t;

    typedef struct packed {
        logic   vld;
        coord_t x;
        coord_t y;
    } tag_t;

    function automatic act_t sat_act(input sum_t v);
        if (v > sum_t'(ACT_MAX))
            return act_t'(ACT_MAX);
        else if (v < sum_t'(ACT_MIN))
            return act_t'(ACT_MIN);
        else
            return act_t'(v);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: one write and one registered read per enable.
// Read data is the prefetched entry for the next accepted column.
module line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] wr_addr,
    input  pix_t          wr_data,
    input  logic [AW-1:0] rd_addr,
    output pix_t          rd_data
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[wr_addr] <= wr_data;
            rd_data      <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/conv3x3.sv
// 3x3 valid convolution over a raster pixel stream with
// a free-running multiply / adder-tree / shift-ReLU-saturate pipeline.
module conv3x3
    import cnn_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int SHIFT = 6,
    parameter int RELU  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [PIX_W-1:0]        pixel_in,
    input  logic                    frame_start,
    input  logic                    w_we,
    input  logic [3:0]              w_addr,
    input  logic signed [WGT_W-1:0] w_data,
    output logic signed [ACT_W-1:0] data_out,
    output logic [COORD_W-1:0]      x_out,
    output logic [COORD_W-1:0]      y_out,
    output logic                    valid_out
);

    localparam int     LB_AW    = $clog2(IMG_W);
    localparam coord_t COL_LAST = coord_t'(IMG_W - 1);
    localparam coord_t ROW_LAST = coord_t'(IMG_H - 1);

    coord_t col;
    coord_t row;
    coord_t cur_col;
    coord_t cur_row;
    coord_t nxt_col;
    coord_t nxt_row;
    logic   win_done;

    always_comb begin
        cur_col  = frame_start ? '0 : col;
        cur_row  = frame_start ? '0 : row;
        nxt_col  = cur_col + 10'd1;
        nxt_row  = cur_row;
        if (cur_col == COL_LAST) begin
            nxt_col = '0;
            nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 10'd1;
        end
        win_done = (cur_row >= 10'd2) && (cur_col >= 10'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            col <= nxt_col;
            row <= nxt_row;
        end
    end

    // Read address is one column ahead so the registered read lines up
    // with the next accepted pixel; a frame_start jump only corrupts row 0.
    pix_t             mid_px;
    pix_t             top_px;
    logic [LB_AW-1:0] wr_a;
    logic [LB_AW-1:0] rd_a;

    assign wr_a = cur_col[LB_AW-1:0];
    assign rd_a = nxt_col[LB_AW-1:0];

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (LB_AW)
    ) u_lb0 (
        .clk     (clk),
        .en      (valid_in),
        .wr_addr (wr_a),
        .wr_data (pixel_in),
        .rd_addr (rd_a),
        .rd_data (mid_px)
    );

    line_buffer #(
        .DEPTH (IMG_W),
        .AW    (LB_AW)
    ) u_lb1 (
        .clk     (clk),
        .en      (valid_in),
        .wr_addr (wr_a),
        .wr_data (mid_px),
        .rd_addr (rd_a),
        .rd_data (top_px)
    );

    pix_t col_px [3];
    pix_t win    [3][2];
    pix_t tap    [NTAPS];

    always_comb begin
        col_px[0] = top_px;
        col_px[1] = mid_px;
        col_px[2] = pixel_in;
        for (int r = 0; r < 3; r++) begin
            tap[r*3]     = win[r][0];
            tap[r*3 + 1] = win[r][1];
            tap[r*3 + 2] = col_px[r];
        end
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= col_px[r];
            end
        end
    end

    wgt_t wgt [NTAPS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAPS; k++)
                wgt[k] <= '0;
        end else begin
            for (int k = 0; k < NTAPS; k++)
                if (w_we && (w_addr == 4'(k)))
                    wgt[k] <= w_data;
        end
    end

    prod_t prod [NTAPS];
    tag_t  t1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= '0;
            for (int k = 0; k < NTAPS; k++)
                prod[k] <= '0;
        end else begin
            t1 <= '{vld: valid_in && win_done,
                    x:   cur_col - 10'd2,
                    y:   cur_row - 10'd2};
            for (int k = 0; k < NTAPS; k++)
                prod[k] <= prod_t'($signed({1'b0, tap[k]}))
                         * prod_t'(wgt[k]);
        end
    end

    sum_t acc;
    sum_t sum;
    tag_t t2;

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++)
            acc = acc + sum_t'(prod[k]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
            t2  <= '0;
        end else begin
            sum <= acc;
            t2  <= t1;
        end
    end

    sum_t sh;
    act_t res;

    always_comb begin
        sh = sum >>> SHIFT;
        if (RELU != 0 && sh[SUM_W-1])
            sh = '0;
        res = sat_act(sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            valid_out <= t2.vld;
            if (t2.vld) begin
                data_out <= res;
                x_out    <= t2.x;
                y_out    <= t2.y;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3.sv
// Random and directed stimulus for conv3x3 checked against a
// frame-level arithmetic model over three parameter sets.
module tb_conv3x3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        vin;
    logic [2:0]        wwe;
    logic [7:0]        pixel;
    logic              fs;
    logic [3:0]        w_addr;
    logic [7:0]        w_data;
    logic signed [11:0] dout [3];
    logic [9:0]        xo [3];
    logic [9:0]        yo [3];
    logic              vo [3];

    always #5 clk = ~clk;

    conv3x3 #(.IMG_W(64), .IMG_H(64), .SHIFT(6), .RELU(1)) u_a (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[0]), .pixel_in(pixel),
        .frame_start(fs), .w_we(wwe[0]), .w_addr(w_addr), .w_data(w_data),
        .data_out(dout[0]), .x_out(xo[0]), .y_out(yo[0]), .valid_out(vo[0]));

    conv3x3 #(.IMG_W(8), .IMG_H(6), .SHIFT(6), .RELU(0)) u_b (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[1]), .pixel_in(pixel),
        .frame_start(fs), .w_we(wwe[1]), .w_addr(w_addr), .w_data(w_data),
        .data_out(dout[1]), .x_out(xo[1]), .y_out(yo[1]), .valid_out(vo[1]));

    conv3x3 #(.IMG_W(5), .IMG_H(4), .SHIFT(0), .RELU(1)) u_c (
        .clk(clk), .rst_n(rst_n), .valid_in(vin[2]), .pixel_in(pixel),
        .frame_start(fs), .w_we(wwe[2]), .w_addr(w_addr), .w_data(w_data),
        .data_out(dout[2]), .x_out(xo[2]), .y_out(yo[2]), .valid_out(vo[2]));

    function automatic int wd(input int d);
        return (d == 0) ? 64 : (d == 1) ? 8 : 5;
    endfunction
    function automatic int hd(input int d);
        return (d == 0) ? 64 : (d == 1) ? 6 : 4;
    endfunction
    function automatic int sd(input int d);
        return (d == 2) ? 0 : 6;
    endfunction
    function automatic int rl(input int d);
        return (d == 1) ? 0 : 1;
    endfunction

    int total = 0;
    int bad = 0;
    int ecnt = 0;
    int cur = 0;
    int wm [3][9];
    int img [64][64];
    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    int got_t [$];
    int lat_q [$];
    logic [31:0] last [3];
    bit late_en = 0;
    int late_k = 0;
    int late_v = 0;

    always @(posedge clk) ecnt <= ecnt + 1;

    function automatic logic [31:0] pack(input int d);
        return {xo[d], yo[d], dout[d]};
    endfunction

    // Output collector plus hold check of idle outputs
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n) begin
                last[d] = '0;
            end else if (vo[d]) begin
                last[d] = pack(d);
                if (d == cur) begin
                    got_q.push_back(last[d]);
                    got_t.push_back(ecnt);
                end
            end else begin
                total++;
                assert (pack(d) === last[d]) else begin
                    bad++;
                    $error("FAIL hold%0d got=%h exp=%h", d, pack(d), last[d]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] g,
                       input logic [31:0] e);
        total++;
        assert (g === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    task automatic clr();
        got_q.delete();
        got_t.delete();
        lat_q.delete();
    endtask

    task automatic set_w(input int d, input int k, input int v);
        wwe[d] = 1'b1;
        w_addr = 4'(k);
        w_data = 8'(v);
        @(negedge clk);
        wwe[d] = 1'b0;
        if (k <= 8)
            wm[d][k] = v;
    endtask

    task automatic rand_w(input int d);
        for (int k = 0; k < 9; k++)
            set_w(d, k, int'($urandom_range(0, 255)) - 128);
    endtask

    task automatic const_w(input int d, input int v0, input int vr);
        for (int k = 0; k < 9; k++)
            set_w(d, k, (k == 0) ? v0 : vr);
    endtask

    task automatic fill_img(input int mode, input int v);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                img[r][c] = (mode == 0) ? v :
                            (mode == 1) ? c : int'($urandom_range(0, 255));
    endtask

    task automatic model_frame(input int d);
        int acc;
        exp_q.delete();
        for (int y = 0; y < hd(d) - 2; y++)
            for (int x = 0; x < wd(d) - 2; x++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += wm[d][i*3 + j] * img[y + i][x + j];
                acc = acc >>> sd(d);
                if (rl(d) != 0 && acc < 0) acc = 0;
                if (acc > 2047) acc = 2047;
                if (acc < -2048) acc = -2048;
                exp_q.push_back({10'(x), 10'(y), 12'(acc)});
            end
    endtask

    task automatic drive(input int d, input int gap, input int npix);
        int n;
        n = 0;
        for (int r = 0; r < hd(d); r++)
            for (int c = 0; c < wd(d); c++)
                if (n < npix) begin
                    while ($urandom_range(0, 99) < gap) @(negedge clk);
                    vin[d] = 1'b1;
                    pixel = 8'(img[r][c]);
                    fs = (n == 0);
                    if (late_en && n == npix - 1) begin
                        wwe[d] = 1'b1;
                        w_addr = 4'(late_k);
                        w_data = 8'(late_v);
                    end
                    if (r >= 2 && c >= 2) lat_q.push_back(ecnt);
                    @(negedge clk);
                    vin[d] = 1'b0;
                    fs = 1'b0;
                    wwe[d] = 1'b0;
                    n++;
                end
        if (late_en) begin
            wm[d][late_k] = late_v;
            late_en = 0;
        end
    endtask

    task automatic check_frame(input string tag, input int want_n);
        repeat (8) @(negedge clk);
        chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
        if (want_n > 0)
            chk({tag, "_n"}, 32'(got_q.size()), 32'(want_n));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk(tag, got_q[i], exp_q[i]);
            if (i < lat_q.size())
                chk({tag, "_lat"}, 32'(got_t[i]), 32'(lat_q[i] + 3));
        end
        clr();
    endtask

    task automatic run(input int d, input string tag, input int gap,
                       input int want_n);
        cur = d;
        model_frame(d);
        drive(d, gap, wd(d) * hd(d));
        check_frame(tag, want_n);
    endtask

    initial begin
        vin = '0;
        wwe = '0;
        pixel = '0;
        fs = 1'b0;
        w_addr = '0;
        w_data = '0;
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 9; k++)
                wm[d][k] = 0;

        repeat (3) @(negedge clk);
        chk("rst_vo_a", {31'b0, vo[0]}, 32'd0);
        chk("rst_out_a", pack(0), 32'd0);
        chk("rst_vo_b", {31'b0, vo[1]}, 32'd0);
        chk("rst_vo_c", {31'b0, vo[2]}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Centre tap 64 on a column ramp gives x+1 everywhere
        set_w(0, 4, 64);
        fill_img(1, 0);
        run(0, "ramp", 0, 3844);

        rand_w(0);
        set_w(0, 12, 55);
        set_w(0, 9, -1);
        fill_img(2, 0);
        run(0, "bubbles", 50, 3844);
        late_en = 1;
        late_k = 8;
        late_v = int'($urandom_range(0, 255)) - 128;
        run(0, "gapless", 0, 3844);
        fill_img(2, 0);
        run(0, "new_w", 25, 0);

        const_w(0, -8, 0);
        fill_img(0, 100);
        run(0, "relu_on", 0, 0);

        const_w(1, -8, 0);
        run(1, "relu_off", 0, 24);
        chk("relu_off_val", {20'b0, dout[1]}, {20'b0, 12'hFF3});

        rand_w(1);
        fill_img(2, 0);
        cur = 1;
        drive(1, 30, 28);
        repeat (8) @(negedge clk);
        clr();
        run(1, "resync", 30, 24);

        const_w(2, 1, 1);
        fill_img(0, 255);
        run(2, "sat_hi", 0, 6);
        chk("sat_val", {20'b0, dout[2]}, 32'h7FF);
        rand_w(2);
        fill_img(2, 0);
        run(2, "c_rand", 50, 6);

        // Mid-frame reset with results in flight
        rand_w(0);
        fill_img(2, 0);
        cur = 0;
        drive(0, 0, 1500);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vo", {31'b0, vo[0]}, 32'd0);
        chk("midrst_out", pack(0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        clr();
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 9; k++)
                wm[d][k] = 0;
        fill_img(2, 0);
        run(0, "post_rst", 0, 3844);
        rand_w(0);
        fill_img(2, 0);
        run(0, "reload", 20, 3844);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
